puc_deadtime_gen: RTL and testbench

// - Dead-time inserter between the PUC switching-state decoder (t1..t6) and the six gate drivers (g1..g6).
// - Three complementary legs: A = (t1 upper, t4 lower), B = (t2, t5), C = (t3, t6).
// - On each commanded transition: the conducting gate is removed, both gates of that leg are held low
//   for DT_CYCLES, then the opposite gate is driven.
// - Also blanks all gates on disable or on a latched fault, and flags shoot-through commands.

---
 rtl/puc_deadtime_gen.sv | 163 ++++++++++++++++
 tb/tb_puc_deadtime_gen.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/puc_deadtime_gen.sv
// ============================================================================
// puc_deadtime_gen : per-leg dead-time inserter between the PUC switching
//                    decoder (t1..t6) and the six gate drivers (g1..g6).
// Revision: 1.0
// ============================================================================
`default_nettype none

module puc_deadtime_gen #(
  parameter int DT_CYCLES = 8,
  parameter int CNT_W     = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic fault,
  input  logic fault_clr,
  input  logic t1,
  input  logic t2,
  input  logic t3,
  input  logic t4,
  input  logic t5,
  input  logic t6,
  output logic g1,
  output logic g2,
  output logic g3,
  output logic g4,
  output logic g5,
  output logic g6,
  output logic fault_latched,
  output logic shoot_err
);

  // One-hot-ish encoding so each gate drive is a plain state flop: {dead, upper, lower}
  localparam logic [2:0] ST_OFF   = 3'b000;
  localparam logic [2:0] ST_DEAD  = 3'b100;
  localparam logic [2:0] ST_UPPER = 3'b010;
  localparam logic [2:0] ST_LOWER = 3'b001;

  localparam logic [CNT_W-1:0] DT_LOAD = CNT_W'(DT_CYCLES - 1);

  logic [5:0] cmd_q;
  logic       fault_latched_q;
  logic       shoot_err_q;
  logic [5:0] gate_w;
  logic       blank_w;
  logic       illegal_w;

  assign blank_w   = ~en | fault_latched_q;
  assign illegal_w = |(cmd_q[2:0] & cmd_q[5:3]);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cmd_q           <= '0;
      fault_latched_q <= 1'b0;
      shoot_err_q     <= 1'b0;
    end else begin
      cmd_q <= {t6, t5, t4, t3, t2, t1};
      if (fault)
        fault_latched_q <= 1'b1;
      else if (fault_clr)
        fault_latched_q <= 1'b0;
      if (illegal_w)
        shoot_err_q <= 1'b1;
      else if (fault_clr && !fault)
        shoot_err_q <= 1'b0;
    end
  end

  // Leg l: upper gate index l, lower gate index l+3 (A=t1/t4, B=t2/t5, C=t3/t6)
  for (genvar l = 0; l < 3; l++) begin : g_leg
    logic [2:0]       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             tgt_q, tgt_d;
    logic             req_hi_w, req_lo_w;

    assign req_hi_w = cmd_q[l] & ~cmd_q[l+3];
    assign req_lo_w = ~cmd_q[l] & cmd_q[l+3];

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        state_q <= ST_OFF;
        cnt_q   <= '0;
        tgt_q   <= 1'b0;
      end else begin
        state_q <= state_d;
        cnt_q   <= cnt_d;
        tgt_q   <= tgt_d;
      end
    end

    always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      tgt_d   = tgt_q;
      if (blank_w) begin
        state_d = ST_OFF;
        cnt_d   = '0;
      end else begin
        case (state_q)
          ST_OFF: begin
            if (req_hi_w || req_lo_w) begin
              state_d = ST_DEAD;
              tgt_d   = req_hi_w;
              cnt_d   = DT_LOAD;
            end
          end
          ST_DEAD: begin
            if (!(req_hi_w || req_lo_w)) begin
              state_d = ST_OFF;
              cnt_d   = '0;
            end else begin
              // Target follows the newest command; the running count is kept
              tgt_d = req_hi_w;
              if (cnt_q == '0)
                state_d = tgt_d ? ST_UPPER : ST_LOWER;
              else
                cnt_d = cnt_q - 1'b1;
            end
          end
          ST_UPPER: begin
            if (req_lo_w) begin
              state_d = ST_DEAD;
              tgt_d   = 1'b0;
              cnt_d   = DT_LOAD;
            end else if (!req_hi_w) begin
              state_d = ST_OFF;
            end
          end
          ST_LOWER: begin
            if (req_hi_w) begin
              state_d = ST_DEAD;
              tgt_d   = 1'b1;
              cnt_d   = DT_LOAD;
            end else if (!req_lo_w) begin
              state_d = ST_OFF;
            end
          end
          default: begin
            state_d = ST_OFF;
            cnt_d   = '0;
          end
        endcase
      end
    end

    always_comb begin
      gate_w[l]   = state_q[1];
      gate_w[l+3] = state_q[0];
    end
  end

  assign g1            = gate_w[0];
  assign g2            = gate_w[1];
  assign g3            = gate_w[2];
  assign g4            = gate_w[3];
  assign g5            = gate_w[4];
  assign g6            = gate_w[5];
  assign fault_latched = fault_latched_q;
  assign shoot_err     = shoot_err_q;

endmodule

`default_nettype wire

// File: tb/tb_puc_deadtime_gen.sv
// ============================================================================
// tb_puc_deadtime_gen : directed + randomized bench against a behavioural
//                       dead-time model.
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_puc_deadtime_gen;

  localparam int DT = 8;

  logic clk = 1'b0;
  logic rst, en, fault, fault_clr;
  logic [5:0] tv;
  logic g1, g2, g3, g4, g5, g6, fl, se;
  logic [5:0] gv;

  int n_chk  = 0;
  int n_fail = 0;

  // Reference: per leg the conducting side (0 none, 1 upper, 2 lower) and the
  // remaining dead cycles (-1 when not waiting).
  int       m_side [3];
  int       m_wait [3];
  logic [5:0] m_cmd;
  logic     m_fl, m_se;

  always #5 clk = ~clk;

  assign gv = {g6, g5, g4, g3, g2, g1};

  puc_deadtime_gen #(.DT_CYCLES(DT), .CNT_W(8)) dut (
    .clk(clk), .rst(rst), .en(en), .fault(fault), .fault_clr(fault_clr),
    .t1(tv[0]), .t2(tv[1]), .t3(tv[2]), .t4(tv[3]), .t5(tv[4]), .t6(tv[5]),
    .g1(g1), .g2(g2), .g3(g3), .g4(g4), .g5(g5), .g6(g6),
    .fault_latched(fl), .shoot_err(se)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic void model_reset();
    for (int l = 0; l < 3; l++) begin
      m_side[l] = 0;
      m_wait[l] = -1;
    end
    m_cmd = '0;
    m_fl  = 1'b0;
    m_se  = 1'b0;
  endfunction

  function automatic void model_step();
    logic blank;
    int   req;
    blank = !en || m_fl;
    for (int l = 0; l < 3; l++) begin
      req = (m_cmd[l] && !m_cmd[l+3]) ? 1 : ((!m_cmd[l] && m_cmd[l+3]) ? 2 : 0);
      if (blank || req == 0) begin
        m_side[l] = 0;
        m_wait[l] = -1;
      end else if (m_wait[l] >= 0) begin
        if (m_wait[l] == 0) begin
          m_side[l] = req;
          m_wait[l] = -1;
        end else begin
          m_wait[l] = m_wait[l] - 1;
        end
      end else if (m_side[l] != req) begin
        m_side[l] = 0;
        m_wait[l] = DT - 1;
      end
    end
    if (|(m_cmd[2:0] & m_cmd[5:3])) m_se = 1'b1;
    else if (fault_clr && !fault)   m_se = 1'b0;
    if (fault)          m_fl = 1'b1;
    else if (fault_clr) m_fl = 1'b0;
    m_cmd = tv;
  endfunction

  function automatic logic [5:0] model_g();
    logic [5:0] g;
    g = '0;
    for (int l = 0; l < 3; l++) begin
      if (m_side[l] == 1) g[l]   = 1'b1;
      if (m_side[l] == 2) g[l+3] = 1'b1;
    end
    return g;
  endfunction

  task automatic check_all();
    chk("gates", {26'd0, gv}, {26'd0, model_g()});
    chk("fault_latched", {31'd0, fl}, {31'd0, m_fl});
    chk("shoot_err", {31'd0, se}, {31'd0, m_se});
    chk("overlap", {29'd0, gv[2:0] & gv[5:3]}, 32'd0);
  endtask

  task automatic cycle();
    @(posedge clk);
    if (!rst) model_step();
    @(negedge clk);
    check_all();
  endtask

  // Counts edges until gate idx reaches val; a timeout shows up as a count mismatch.
  task automatic wait_for(input string tag, input int idx, input logic val, input int exp_edges);
    int n;
    n = 0;
    do begin
      cycle();
      n++;
    end while (gv[idx] !== val && n < 40);
    chk(tag, n, exp_edges);
  endtask

  task automatic async_reset();
    #2 rst = 1'b1;
    #1;
    chk("rst_gates", {26'd0, gv}, 32'd0);
    chk("rst_fault_latched", {31'd0, fl}, 32'd0);
    chk("rst_shoot_err", {31'd0, se}, 32'd0);
    model_reset();
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    logic [5:0] nt;
    int         leg;
    rst = 1'b1; en = 1'b0; fault = 1'b0; fault_clr = 1'b0; tv = '0;
    model_reset();
    repeat (2) @(negedge clk);
    check_all();
    rst = 1'b0;

    // Power-up: 101010 -> g1,g3,g5 after input register plus dead time
    en = 1'b1; tv = 6'b010101;
    wait_for("first_rise_g1", 0, 1'b1, DT + 2);
    repeat (5) cycle();

    // Leg C flips 101010 -> 100011
    tv = 6'b110001;
    wait_for("g3_fall", 2, 1'b0, 2);
    wait_for("g6_rise", 5, 1'b1, DT);
    repeat (3) cycle();

    // Leg C toggled every 3 cycles
    for (int i = 0; i < 8; i++) begin
      tv = (i % 2 == 0) ? 6'b010101 : 6'b110001;
      repeat (3) cycle();
    end
    repeat (12) cycle();

    // One-cycle shoot-through request
    tv = 6'b111111;
    cycle();
    tv = 6'b010101;
    repeat (14) cycle();
    fault_clr = 1'b1;
    cycle();
    fault_clr = 1'b0;
    repeat (3) cycle();

    // Fault latching and clearing
    fault = 1'b1;
    cycle();
    fault_clr = 1'b1;
    cycle();
    fault = 1'b0; fault_clr = 1'b0;
    repeat (3) cycle();
    fault_clr = 1'b1;
    cycle();
    fault_clr = 1'b0;
    repeat (12) cycle();

    // Asynchronous reset while conducting, then idle until enabled
    async_reset();
    en = 1'b0;
    repeat (4) cycle();
    en = 1'b1;
    repeat (12) cycle();

    // Randomized operation
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 7) == 0) begin
        nt = '0;
        for (leg = 0; leg < 3; leg++) begin
          case ($urandom_range(0, 19))
            0:                nt[leg] = 1'b0;
            1:                begin nt[leg] = 1'b1; nt[leg+3] = 1'b1; end
            2, 3:             nt = nt;
            4, 5, 6, 7, 8, 9, 10, 11: nt[leg] = 1'b1;
            default:          nt[leg+3] = 1'b1;
          endcase
        end
        tv = nt;
      end
      en        = ($urandom_range(0, 59) != 0);
      fault     = ($urandom_range(0, 79) == 0);
      fault_clr = ($urandom_range(0, 19) == 0);
      if ($urandom_range(0, 499) == 0) async_reset();
      cycle();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL timeout: simulation did not finish, expected completion");
    $fatal(1);
  end

endmodule

`default_nettype wire
